// File: rtl/boot_pkg.sv
// Shared types and helpers for the boot sequencer slice.
// State encoding is visible on the status port.
package boot_pkg;

  localparam int STATUS_W  = 3;
  localparam int BLINK_BIT = 23;

  typedef enum logic [STATUS_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_STAGE = 3'd1,
    ST_HOLD  = 3'd2,
    ST_RUN   = 3'd3,
    ST_FAULT = 3'd4
  } boot_state_e;

  function automatic int cnt_w(input int v);
    return (v <= 0) ? 1 : $clog2(v + 1);
  endfunction

endpackage

// File: rtl/boot_sequencer_if.sv
// Board-facing bundle of the boot sequencer: button, stage
// handshakes and status outputs.
interface boot_sequencer_if #(
  parameter int NUM_STAGES = 2
);
  import boot_pkg::*;

  logic                  btn_n;
  logic [NUM_STAGES-1:0] stage_ready;
  logic [NUM_STAGES-1:0] stage_en;
  logic                  cpu_reset;
  logic                  boot_done;
  logic                  boot_error;
  logic                  led_n;
  logic [STATUS_W-1:0]   status;

  modport master (
    input  btn_n, stage_ready,
    output stage_en, cpu_reset, boot_done,
    output boot_error, led_n, status
  );

  modport slave (
    output btn_n, stage_ready,
    input  stage_en, cpu_reset, boot_done,
    input  boot_error, led_n, status
  );

endinterface

// File: rtl/button_debounce.sv
// Synchroniser, debouncer and press-length classifier for an
// active-low push button; all outputs are registered pulses.
module button_debounce
  import boot_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter int LONG_CYCLES     = 2**24
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n_i,
  output logic pressed_o,
  output logic short_release_o,
  output logic long_hit_o
);

  localparam int DW = cnt_w(DEBOUNCE_CYCLES);
  localparam int LW = cnt_w(LONG_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   deb_q, deb_d;
  logic [DW-1:0]          dcnt_q, dcnt_d;
  logic [LW-1:0]          len_q, len_d;
  logic                   prs_q, prs_d;
  logic                   srel_q, srel_d;
  logic                   long_q, long_d;
  logic                   raw_down;

  assign raw_down = ~sync_q[SYNC_STAGES-1];

  always_comb begin
    deb_d  = deb_q;
    dcnt_d = '0;
    len_d  = len_q;
    prs_d  = 1'b0;
    srel_d = 1'b0;
    long_d = 1'b0;
    if (raw_down != deb_q) begin
      if (dcnt_q >= DW'(DEBOUNCE_CYCLES - 1))
        deb_d = raw_down;
      else
        dcnt_d = dcnt_q + 1'b1;
    end
    if (deb_d && !deb_q) begin
      prs_d = 1'b1;
      len_d = '0;
    end else if (!deb_d && deb_q) begin
      // a press that already fired long_hit must not also count as warm
      srel_d = (len_q != LW'(LONG_CYCLES));
      len_d  = '0;
    end else if (deb_q && len_q != LW'(LONG_CYCLES)) begin
      len_d  = len_q + 1'b1;
      long_d = (len_d == LW'(LONG_CYCLES));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '1;
      deb_q  <= 1'b0;
      dcnt_q <= '0;
      len_q  <= '0;
      prs_q  <= 1'b0;
      srel_q <= 1'b0;
      long_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_n_i};
      deb_q  <= deb_d;
      dcnt_q <= dcnt_d;
      len_q  <= len_d;
      prs_q  <= prs_d;
      srel_q <= srel_d;
      long_q <= long_d;
    end
  end

  assign pressed_o       = prs_q;
  assign short_release_o = srel_q;
  assign long_hit_o      = long_q;

endmodule

// File: rtl/boot_sequencer.sv
// Brings boot stages up in order, holds the CPU in reset until
// all are ready, and handles warm/cold button reboots.
module boot_sequencer
  import boot_pkg::*;
#(
  parameter int NUM_STAGES      = 2,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter int HOLD_CYCLES     = 16,
  parameter int LONG_CYCLES     = 2**24,
  parameter int TIMEOUT_CYCLES  = 2**26
) (
  input logic               clk,
  input logic               reset,
  boot_sequencer_if.master  bus
);

  localparam int IW = cnt_w(NUM_STAGES - 1);
  localparam int TW = cnt_w(TIMEOUT_CYCLES);
  localparam int HW = cnt_w(HOLD_CYCLES);

  boot_state_e           state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [TW-1:0]         tmr_q, tmr_d;
  logic [HW-1:0]         hold_q, hold_d;
  logic [NUM_STAGES-1:0] en_q, en_d;
  logic                  prs_q, prs_d;
  logic                  cpu_q, cpu_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  led_q, led_d;
  logic [BLINK_BIT:0]    free_q;
  logic                  pressed, short_rel, long_hit;
  logic                  rdy_cur, last;

  button_debounce #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .LONG_CYCLES     (LONG_CYCLES)
  ) u_btn (
    .clk             (clk),
    .reset           (reset),
    .btn_n_i         (bus.btn_n),
    .pressed_o       (pressed),
    .short_release_o (short_rel),
    .long_hit_o      (long_hit)
  );

  always_comb begin
    rdy_cur = 1'b0;
    for (int i = 0; i < NUM_STAGES; i++)
      if (idx_q == IW'(i)) rdy_cur = bus.stage_ready[i];
    last = (idx_q == IW'(NUM_STAGES - 1));
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tmr_d   = tmr_q;
    hold_d  = hold_q;
    en_d    = en_q;
    prs_d   = prs_q;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_STAGE;
        idx_d   = '0;
        tmr_d   = '0;
      end
      ST_STAGE: begin
        if (rdy_cur) begin
          tmr_d = '0;
          if (last) begin
            state_d = ST_HOLD;
            hold_d  = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else if (TIMEOUT_CYCLES != 0 &&
                     tmr_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d = ST_FAULT;
        end else if (tmr_q != '1) begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      ST_HOLD: begin
        if (hold_q == HW'(HOLD_CYCLES - 1))
          state_d = ST_RUN;
        else
          hold_d = hold_q + 1'b1;
      end
      ST_RUN: begin
        if ((bus.stage_ready & en_q) != en_q)
          state_d = ST_FAULT;
      end
      ST_FAULT: ;
      default: state_d = ST_IDLE;
    endcase

    // a stage failure in the same cycle outranks a warm release
    if (short_rel && state_d != ST_FAULT &&
        (state_q == ST_RUN || state_q == ST_HOLD)) begin
      state_d = ST_HOLD;
      hold_d  = '0;
    end
    if (long_hit) begin
      state_d = ST_IDLE;
      en_d    = '0;
      idx_d   = '0;
      tmr_d   = '0;
      hold_d  = '0;
    end

    for (int i = 0; i < NUM_STAGES; i++)
      if (state_d == ST_STAGE && idx_d == IW'(i)) en_d[i] = 1'b1;

    if (long_hit || short_rel) prs_d = 1'b0;
    else if (pressed)          prs_d = 1'b1;

    cpu_d  = (state_d != ST_RUN) || prs_d;
    done_d = (state_d == ST_RUN);
    err_d  = (state_d == ST_FAULT);
    led_d  = 1'b1;
    if (state_d == ST_RUN)   led_d = 1'b0;
    if (state_d == ST_FAULT) led_d = free_q[BLINK_BIT];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      tmr_q   <= '0;
      hold_q  <= '0;
      en_q    <= '0;
      prs_q   <= 1'b0;
      cpu_q   <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      led_q   <= 1'b1;
      free_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tmr_q   <= tmr_d;
      hold_q  <= hold_d;
      en_q    <= en_d;
      prs_q   <= prs_d;
      cpu_q   <= cpu_d;
      done_q  <= done_d;
      err_q   <= err_d;
      led_q   <= led_d;
      free_q  <= free_q + 1'b1;
    end
  end

  assign bus.stage_en   = en_q;
  assign bus.cpu_reset  = cpu_q;
  assign bus.boot_done  = done_q;
  assign bus.boot_error = err_q;
  assign bus.led_n      = led_q;
  assign bus.status     = state_q;

endmodule
